// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_addsub_pkg
// Purpose : Shared state encoding for the bit-serial adder/subtractor.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package serial_addsub_pkg;

  // IDLE waits for start, SHIFT processes one bit per clock,
  // DONE holds the single-cycle completion pulse.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage : serial_addsub_pkg
`default_nettype wire

// File: rtl/serial_fa_cell.sv
`default_nettype none
// ============================================================================
// Module  : serial_fa_cell
// Purpose : 1-bit combinational full adder, the single arithmetic cell that
//           the serial adder/subtractor reuses for every bit position.
// Ports   : i_a, i_b, i_cin  -> operand bits and carry in
//           o_s, o_co        <- sum bit and carry out
// Revision: 1.0  initial release
// ============================================================================
module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_cin;
  assign o_co = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule : serial_fa_cell
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module  : serial_addsub
// Purpose : Bit-serial adder/subtractor. Operands are captured on start and
//           processed LSB-first through one full-adder cell with a registered
//           carry; sum, carry-out and signed overflow appear with a done pulse
//           WIDTH cycles after acceptance.
// Ports   : clk, rst_n (async active-low)
//           start, sub, a, b    -> request, mode (1 = a-b), operands
//           busy, done          <- processing flag, completion pulse
//           sum, cout, ovf      <- result, carry out of MSB, signed overflow
// Revision: 1.0  initial release
// ============================================================================
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_PENULT = CW'(WIDTH - 2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cmsb_in;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_s;
  logic             w_c;
  logic             w_load;
  logic             w_last;

  serial_fa_cell u_fa (
    .i_a   (r_a_sh[0]),
    .i_b   (r_b_sh[0]),
    .i_cin (r_carry),
    .o_s   (w_s),
    .o_co  (w_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign w_acc_nxt = (r_acc >> 1) | {w_s, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == c_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert b at load and seed the carry with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_cmsb_in <= 1'b0;
    end else if (w_load) begin
      r_a_sh    <= a;
      r_b_sh    <= sub ? ~b : b;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_carry   <= sub;
      r_cmsb_in <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_acc   <= w_acc_nxt;
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
      // Carry out of bit WIDTH-2 is the carry into the MSB, needed for ovf.
      if (r_cnt == c_PENULT) r_cmsb_in <= w_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_c;
        r_ovf  <= w_c ^ r_cmsb_in;
      end
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule : serial_addsub
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_addsub
// Purpose : Self-checking bench for serial_addsub (WIDTH=8 and WIDTH=2).
// Revision: 1.0  initial release
// ============================================================================
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       start2, sub2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] prev_sum;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_addsub #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: unsigned/signed integer arithmetic on w-bit values.
  function automatic void ref_op(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                 input logic s, output logic [31:0] rs,
                                 output logic rc, output logic ro);
    longint m, ua, ub, sa, sb, r;
    m  = longint'(1) << w;
    ua = longint'(ai);
    ub = longint'(bi);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      r  = sa - sb;
      rs = 32'(((ua - ub) % m + m) % m);
      rc = (ua >= ub);
    end else begin
      r  = sa + sb;
      rs = 32'((ua + ub) % m);
      rc = ((ua + ub) >= m);
    end
    ro = (r < -(m / 2)) || (r >= m / 2);
  endfunction

  // One WIDTH=8 operation; called at a negedge, returns at the negedge after done.
  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic si,
                      input logic [7:0] es, input logic ec, input logic eo);
    start = 1'b1; a = ai; b = bi; sub = si;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sub = $urandom;
    chk("busy_after_accept", busy, 1);
    chk("done_after_accept", done, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        if (busy !== 1'b1 || done !== 1'b0) chk("busy_window", {busy, done}, 2'b10);
        if (sum !== prev_sum) chk("sum_held", sum, prev_sum);
      end
    end
    chk("busy_at_done", busy, 0);
    chk("done_pulse", done, 1);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("ovf", ovf, eo);
    prev_sum = es;
  endtask

  task automatic run2(input logic [1:0] ai, input logic [1:0] bi, input logic si);
    logic [31:0] es;
    logic ec, eo;
    ref_op(2, 32'(ai), 32'(bi), si, es, ec, eo);
    start2 = 1'b1; a2 = ai; b2 = bi; sub2 = si;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    if (done2 !== 1'b0) chk("w2_early_done", done2, 0);
    @(negedge clk);
    chk("w2_done", done2, 1);
    chk("w2_result", {sum2, cout2, ovf2}, {es[1:0], ec, eo});
  endtask

  logic [7:0] qa[64];
  logic [7:0] qb[64];
  logic       qs[64];

  initial begin
    logic [31:0] rs;
    logic rc, ro;
    logic [7:0] ra, rb;
    logic rsb;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    prev_sum = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, done, sum, cout, ovf}, 12'h000);
    chk("rst_outputs_w2", {busy2, done2, sum2, cout2, ovf2}, 6'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 6; i++)
      run8(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].co, tbl[i].ov);
    @(negedge clk);
    chk("done_single_pulse", done, 0);

    // Random single operations against the model.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rsb = $urandom;
      ref_op(8, 32'(ra), 32'(rb), rsb, rs, rc, ro);
      run8(ra, rb, rsb, rs[7:0], rc, ro);
    end
    @(negedge clk);

    // start held high with changing operands: accepted every 9 cycles.
    for (int cyc = 0; cyc < 45; cyc++) begin
      start = 1'b1; qa[cyc] = $urandom; qb[cyc] = $urandom; qs[cyc] = $urandom;
      a = qa[cyc]; b = qb[cyc]; sub = qs[cyc];
      @(negedge clk);
      if (busy !== ((cyc % 9) != 8)) chk("b2b_busy", busy, ((cyc % 9) != 8));
      if (cyc >= 8 && ((cyc - 8) % 9) == 0) begin
        ref_op(8, 32'(qa[cyc-8]), 32'(qb[cyc-8]), qs[cyc-8], rs, rc, ro);
        chk("b2b_done", done, 1);
        chk("b2b_result", {sum, cout, ovf}, {rs[7:0], rc, ro});
        prev_sum = rs[7:0];
      end else if (done !== 1'b0) begin
        chk("b2b_spurious_done", done, 0);
      end
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Asynchronous reset during SHIFT cycle 4.
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear", {busy, done, sum, cout, ovf}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      chk("no_done_after_abort", seen, 0);
    end
    chk("sum_after_abort", sum, 8'h00);
    prev_sum = 8'h00;
    run8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);

    // WIDTH=2 exhaustive.
    @(negedge clk);
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++)
          run2(2'(x), 2'(y), s[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_serial_addsub
`default_nettype wire
